// File: rtl/lzc.sv
// Streaming leading-zero counter: accumulates per-word leading zeros over a
// group of `word` input words (MS word first) and reports one count per group.
module lzc #(
  parameter int width = 8,
  parameter int word  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [width-1:0]                  data,
  input  logic                              Ivalid,
  input  logic                              mode,
  output logic [$clog2(width*word):0]       zeros,
  output logic                              Ovalid
);

  localparam int ZW = $clog2(width*word) + 1;
  localparam int CW = $clog2(word) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(word - 1);

  // Handshake: Ivalid alone qualifies data (no backpressure); a word is taken
  // on every rising edge with Ivalid=1. Ovalid is a one-cycle result strobe.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ZW-1:0] acc_q, acc_d;
  logic          found_q, found_d;
  logic          mode_q, mode_d;
  logic [ZW-1:0] zeros_q, zeros_d;
  logic          ovalid_q, ovalid_d;

  logic [ZW-1:0] word_lz;
  logic [ZW-1:0] acc_nxt;
  logic          grp_mode;
  logic          has_one;
  logic          last_word;

  // Priority encoder: ascending scan so the highest set bit wins.
  always_comb begin
    word_lz = ZW'(width);
    for (int i = 0; i < width; i++) begin
      if (data[i]) word_lz = ZW'(width - 1 - i);
    end
  end

  always_comb begin
    has_one   = |data;
    grp_mode  = (cnt_q == '0) ? mode : mode_q;
    acc_nxt   = found_q ? acc_q : acc_q + word_lz;
    last_word = (cnt_q == LAST_IDX) || (grp_mode && has_one);

    cnt_d    = cnt_q;
    acc_d    = acc_q;
    found_d  = found_q;
    mode_d   = mode_q;
    zeros_d  = zeros_q;
    ovalid_d = 1'b0;

    if (Ivalid) begin
      mode_d = grp_mode;
      if (last_word) begin
        zeros_d  = acc_nxt;
        ovalid_d = 1'b1;
        cnt_d    = '0;
        acc_d    = '0;
        found_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        acc_d   = acc_nxt;
        found_d = found_q | has_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      found_q  <= 1'b0;
      mode_q   <= 1'b0;
      zeros_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      found_q  <= found_d;
      mode_q   <= mode_d;
      zeros_q  <= zeros_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign zeros  = zeros_q;
  assign Ovalid = ovalid_q;

endmodule

// File: tb/tb_lzc.sv
// Bench for lzc: directed groups with fixed expected counts, then random
// groups checked against a concatenated-vector leading-zero model.
module tb_lzc;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int ZW = $clog2(W*N) + 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  data;
  logic          Ivalid;
  logic          mode;
  logic [ZW-1:0] zeros;
  logic          Ovalid;

  logic [ZW-1:0] exp_q[$];
  int n_cmp;
  int n_bad;

  // group model state for random stimulus
  logic [W*N-1:0] m_grp;
  int             m_cnt;
  logic           m_mode;

  lzc #(.width(W), .word(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .Ivalid (Ivalid),
    .mode   (mode),
    .zeros  (zeros),
    .Ovalid (Ovalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // drivers: all called at a negedge, return at the next negedge
  task automatic drive_word(input logic [W-1:0] d, input logic m);
    data   = d;
    mode   = m;
    Ivalid = 1'b1;
    @(negedge clk);
    Ivalid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      Ivalid = 1'b0;
      data   = W'($urandom_range(0, (1 << W) - 1));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_zeros", 32'(zeros), 0);
    check_val("rst_ovalid", 32'(Ovalid), 0);
    rst_n  = 1'b0;
    m_cnt  = 0;
    m_grp  = '0;
    m_mode = 1'b0;
  endtask

  function automatic int model_lz(input logic [W*N-1:0] v);
    for (int b = W*N-1; b >= 0; b--) begin
      if (v[b]) return W*N-1-b;
    end
    return W*N;
  endfunction

  // random driver: pushes the model's expectation on each completing word
  task automatic model_word(input logic [W-1:0] d, input logic m);
    if (m_cnt == 0) begin
      m_mode = m;
      m_grp  = '0;
    end
    m_grp[(N-1-m_cnt)*W +: W] = d;
    if (m_cnt == N-1 || (m_mode && d != '0)) begin
      exp_q.push_back(ZW'(model_lz(m_grp)));
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    drive_word(d, m);
  endtask

  // scoreboard: every Ovalid pops one expectation
  always @(negedge clk) begin
    if (!rst_n && Ovalid === 1'b1) begin
      if (exp_q.size() == 0) check_val("unexpected_ovalid", 1, 0);
      else check_val("zeros", 32'(zeros), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [W-1:0] rd;
    n_cmp  = 0;
    n_bad  = 0;
    data   = '0;
    Ivalid = 1'b0;
    mode   = 1'b0;
    rst_n  = 1'b1;
    m_cnt  = 0;
    m_grp  = '0;
    m_mode = 1'b0;
    @(negedge clk);
    do_reset();
    gap(2);

    // all-zero group: maximum count
    drive_word(8'h00, 0);
    drive_word(8'h00, 0);
    drive_word(8'h00, 0);
    exp_q.push_back(32);
    drive_word(8'h00, 0);
    gap(2);

    // non-contiguous words, acc frozen after first one
    drive_word(8'h3F, 0); gap(1);
    drive_word(8'h3F, 0); gap(1);
    drive_word(8'h3F, 0); gap(1);
    exp_q.push_back(2);
    drive_word(8'h00, 0);
    gap(2);

    // contiguous mixed group
    drive_word(8'h00, 0);
    drive_word(8'h10, 0);
    drive_word(8'h3F, 0);
    exp_q.push_back(11);
    drive_word(8'hFF, 0);
    gap(2);

    // reset mid-group discards the partial group
    drive_word(8'h00, 0);
    drive_word(8'h00, 0);
    do_reset();
    drive_word(8'h01, 0);
    drive_word(8'hFF, 0);
    drive_word(8'hFF, 0);
    exp_q.push_back(7);
    drive_word(8'hFF, 0);
    gap(2);

    // early termination with back-to-back completions
    drive_word(8'h00, 1);
    exp_q.push_back(13);
    drive_word(8'h04, 1);
    exp_q.push_back(0);
    drive_word(8'h80, 1);
    check_val("b2b_ovalid", 32'(Ovalid), 1);
    drive_word(8'h00, 1);
    gap(2);
    do_reset();

    // mode change mid-group ignored
    drive_word(8'h40, 0);
    drive_word(8'h00, 1);
    drive_word(8'h00, 1);
    exp_q.push_back(1);
    drive_word(8'h00, 1);
    gap(3);
    check_val("directed_drain", 32'(exp_q.size()), 0);

    // random groups against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = W'($urandom_range(0, (1 << W) - 1));
        1:       rd = W'(1 << $urandom_range(0, W-1));
        default: rd = '0;
      endcase
      model_word(rd, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
    end
    gap(3);
    check_val("final_drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
